hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 255: maximum consecutive mem_busy cycles before the error flag sets.
REQ-002 SHALL have parameter CNT_W, default 16: width of the stall performance counter.
REQ-003 SHALL have port clk, input, 1 bit: single clock, all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have ports ID_rs1_addr and ID_rs2_addr, input, 5 bits each: source registers of the instruction in ID.
REQ-006 SHALL have ports ID_use_rs1 and ID_use_rs2, input, 1 bit each: the ID instruction reads rs1 / rs2.
REQ-007 SHALL have ports EX_reg_addr (input, 5 bits), EX_mem_read (input, 1 bit) and EX_reg_wen (input, 1 bit): destination register and controls from the ID/EX gate outputs.
REQ-008 SHALL have port EX_redirect, input, 1 bit: taken branch, jal or jalr resolved in EX.
REQ-009 SHALL have port mem_busy, input, 1 bit: the data memory is not ready this cycle.
REQ-010 SHALL have outputs pc_stall, IF_ID_stall, IF_ID_flush, ID_EX_hold, ID_EX_flush and EX_MEM_stall, 1 bit each: pipeline controls; ID_EX_flush drives the is_stall bubble input of the ID/EX gate.
REQ-011 SHALL have output state, 2 bits: current FSM state.
REQ-012 SHALL have outputs stall_cnt (CNT_W bits), mem_timeout_err (1 bit) and busy_cnt (8 bits).

Function
REQ-013 SHALL define load_use = EX_mem_read & EX_reg_wen & (EX_reg_addr != 0) & ((ID_use_rs1 & ID_rs1_addr == EX_reg_addr) | (ID_use_rs2 & ID_rs2_addr == EX_reg_addr)).
REQ-014 SHALL drive all control outputs combinationally from the current inputs, with priority mem_busy > EX_redirect > load_use.
REQ-015 SHALL, when mem_busy=1, assert pc_stall, IF_ID_stall, ID_EX_hold and EX_MEM_stall, and deassert both flush outputs; a redirect or load-use present in the same cycle is deferred, not lost.
REQ-016 SHALL, when mem_busy=0 and EX_redirect=1, assert IF_ID_flush and ID_EX_flush, with all stall and hold outputs at 0.
REQ-017 SHALL, when mem_busy=0, EX_redirect=0 and load_use=1, assert pc_stall, IF_ID_stall and ID_EX_flush; this inserts exactly one bubble.
REQ-018 SHALL otherwise drive all control outputs to 0.
REQ-019 SHALL implement FSM states RUN=0, LU_STALL=1, MEM_WAIT=2 and REDIR=3; the next state is the condition that won priority this cycle, or RUN if none.
REQ-020 SHALL, in state LU_STALL, suppress load_use for one cycle only, so one load produces at most one bubble.
REQ-021 SHALL increment stall_cnt on every cycle in which pc_stall=1, saturating at all-ones with no wrap.
REQ-022 SHALL count consecutive mem_busy cycles in busy_cnt, saturating at 255, and clear it on the first cycle with mem_busy=0.
REQ-023 SHALL set mem_timeout_err on the edge at which busy_cnt reaches MEM_TIMEOUT with mem_busy=1; the flag is sticky until reset.
REQ-024 SHALL treat writes to x0 (EX_reg_addr=0) as no hazard.

Reset
REQ-025 SHALL, on a clock edge with rst=1, set state=RUN, stall_cnt=0, busy_cnt=0 and mem_timeout_err=0.
REQ-026 SHALL hold all control outputs at 0 while rst=1, regardless of other inputs.
REQ-027 SHALL abandon any stall or wait in progress when rst is asserted mid-operation, and restart in RUN on the first cycle after rst deasserts.

Verification
REQ-028 Load-use: EX_mem_read=1, EX_reg_wen=1, EX_reg_addr=5, ID_rs1_addr=5, ID_use_rs1=1 -> pc_stall=IF_ID_stall=ID_EX_flush=1 for exactly 1 cycle; state=1 next cycle; stall_cnt=1.
REQ-029 x0 destination: same as REQ-028 but EX_reg_addr=0, ID_rs1_addr=0 -> no stall; stall_cnt stays 0.
REQ-030 Redirect with load-use: EX_redirect=1 together with a load-use hazard -> IF_ID_flush=ID_EX_flush=1 and pc_stall=0; state=3 next cycle.
REQ-031 Memory wait with redirect: mem_busy=1 for 3 cycles while EX_redirect=1 -> 3 cycles with stalls and ID_EX_hold=1 and no flush; flush on the 4th cycle; stall_cnt=3.
REQ-032 Timeout: MEM_TIMEOUT=4, mem_busy held 6 cycles -> mem_timeout_err=1 after the 4th edge and still 1 after mem_busy=0; cleared only by rst.
REQ-033 Reset mid-wait: rst=1 during MEM_WAIT -> next cycle state=0, stall_cnt=0, all control outputs 0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, redirect flushes, data-memory wait
// stalls, plus a stall performance counter and a sticky memory-timeout flag.
module hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       ID_rs1_addr,
  input  logic [4:0]       ID_rs2_addr,
  input  logic             ID_use_rs1,
  input  logic             ID_use_rs2,
  input  logic [4:0]       EX_reg_addr,
  input  logic             EX_mem_read,
  input  logic             EX_reg_wen,
  input  logic             EX_redirect,
  input  logic             mem_busy,
  output logic             pc_stall,
  output logic             IF_ID_stall,
  output logic             IF_ID_flush,
  output logic             ID_EX_hold,
  output logic             ID_EX_flush,
  output logic             EX_MEM_stall,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             mem_timeout_err,
  output logic [7:0]       busy_cnt
);

  localparam int unsigned BusyW = 8;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2,
    REDIR    = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [BusyW-1:0]   busy_cnt_q, busy_cnt_d;
  logic               timeout_q, timeout_d;
  logic               lu_match;
  logic               load_use;

  // A load to x0 never creates a dependency.
  assign lu_match = EX_mem_read && EX_reg_wen && (EX_reg_addr != 5'd0) &&
                    ((ID_use_rs1 && (ID_rs1_addr == EX_reg_addr)) ||
                     (ID_use_rs2 && (ID_rs2_addr == EX_reg_addr)));

  // The cycle after a bubble the same load is still seen; suppress it once.
  assign load_use = lu_match && (state_q != LU_STALL);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      stall_cnt_q <= '0;
      busy_cnt_q  <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      busy_cnt_q  <= busy_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  // Priority: mem_busy > EX_redirect > load_use; everything low during reset.
  always_comb begin
    pc_stall     = 1'b0;
    IF_ID_stall  = 1'b0;
    IF_ID_flush  = 1'b0;
    ID_EX_hold   = 1'b0;
    ID_EX_flush  = 1'b0;
    EX_MEM_stall = 1'b0;
    state_d      = RUN;
    if (!rst) begin
      if (mem_busy) begin
        pc_stall     = 1'b1;
        IF_ID_stall  = 1'b1;
        ID_EX_hold   = 1'b1;
        EX_MEM_stall = 1'b1;
        state_d      = MEM_WAIT;
      end else if (EX_redirect) begin
        IF_ID_flush  = 1'b1;
        ID_EX_flush  = 1'b1;
        state_d      = REDIR;
      end else if (load_use) begin
        pc_stall     = 1'b1;
        IF_ID_stall  = 1'b1;
        ID_EX_flush  = 1'b1;
        state_d      = LU_STALL;
      end
    end
  end

  // Saturating counters and the sticky timeout flag.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    busy_cnt_d  = '0;
    timeout_d   = timeout_q;
    if (pc_stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (mem_busy) begin
      busy_cnt_d = (busy_cnt_q == {BusyW{1'b1}}) ? busy_cnt_q : busy_cnt_q + BusyW'(1);
      if (32'(busy_cnt_d) >= MEM_TIMEOUT) begin
        timeout_d = 1'b1;
      end
    end
  end

  assign state           = state_q;
  assign stall_cnt       = stall_cnt_q;
  assign busy_cnt        = busy_cnt_q;
  assign mem_timeout_err = timeout_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (MEM_TIMEOUT=4, CNT_W=4).
module tb_hazard_ctrl;

  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [4:0]    ID_rs1_addr, ID_rs2_addr, EX_reg_addr;
  logic          ID_use_rs1, ID_use_rs2, EX_mem_read, EX_reg_wen, EX_redirect, mem_busy;
  logic          pc_stall, IF_ID_stall, IF_ID_flush, ID_EX_hold, ID_EX_flush, EX_MEM_stall;
  logic [1:0]    state;
  logic [CW-1:0] stall_cnt;
  logic          mem_timeout_err;
  logic [7:0]    busy_cnt;
  logic [5:0]    ctrl;

  int checks   = 0;
  int failures = 0;

  localparam logic [5:0] IDLE = 6'b000000;
  localparam logic [5:0] LU   = 6'b110010;
  localparam logic [5:0] REDR = 6'b001010;
  localparam logic [5:0] MEMW = 6'b110101;

  always #5 clk = ~clk;

  assign ctrl = {pc_stall, IF_ID_stall, IF_ID_flush, ID_EX_hold, ID_EX_flush, EX_MEM_stall};

  hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .ID_rs1_addr(ID_rs1_addr), .ID_rs2_addr(ID_rs2_addr),
    .ID_use_rs1(ID_use_rs1), .ID_use_rs2(ID_use_rs2),
    .EX_reg_addr(EX_reg_addr), .EX_mem_read(EX_mem_read), .EX_reg_wen(EX_reg_wen),
    .EX_redirect(EX_redirect), .mem_busy(mem_busy),
    .pc_stall(pc_stall), .IF_ID_stall(IF_ID_stall), .IF_ID_flush(IF_ID_flush),
    .ID_EX_hold(ID_EX_hold), .ID_EX_flush(ID_EX_flush), .EX_MEM_stall(EX_MEM_stall),
    .state(state), .stall_cnt(stall_cnt), .mem_timeout_err(mem_timeout_err),
    .busy_cnt(busy_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ID_rs1_addr = 5'd0; ID_rs2_addr = 5'd0; EX_reg_addr = 5'd0;
    ID_use_rs1 = 1'b0; ID_use_rs2 = 1'b0; EX_mem_read = 1'b0; EX_reg_wen = 1'b0;
    EX_redirect = 1'b0; mem_busy = 1'b0;
  endtask

  task automatic set_lu(input logic [4:0] rd);
    EX_mem_read = 1'b1; EX_reg_wen = 1'b1; EX_reg_addr = rd;
    ID_rs1_addr = rd; ID_use_rs1 = 1'b1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    set_lu(5'd5);
    mem_busy = 1'b1;
    EX_redirect = 1'b1;
    #1;
    checks++; if (ctrl !== IDLE) begin failures++; $display("FAIL reset_ctrl got=%b exp=%b", ctrl, IDLE); end
    tick();
    checks++; if (state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state); end
    checks++; if (stall_cnt !== 4'd0 || busy_cnt !== 8'd0 || mem_timeout_err !== 1'b0) begin
      failures++; $display("FAIL reset_regs got=%0d/%0d/%b exp=0/0/0", stall_cnt, busy_cnt, mem_timeout_err); end
    idle_inputs();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_load_use();
    do_reset();
    set_lu(5'd5);
    #1;
    checks++; if (ctrl !== LU) begin failures++; $display("FAIL lu_ctrl got=%b exp=%b", ctrl, LU); end
    tick();
    checks++; if (state !== 2'd1) begin failures++; $display("FAIL lu_state got=%0d exp=1", state); end
    checks++; if (stall_cnt !== 4'd1) begin failures++; $display("FAIL lu_cnt got=%0d exp=1", stall_cnt); end
    #1;
    checks++; if (ctrl !== IDLE) begin failures++; $display("FAIL lu_suppress got=%b exp=%b", ctrl, IDLE); end
    tick();
    checks++; if (state !== 2'd0 || stall_cnt !== 4'd1) begin
      failures++; $display("FAIL lu_after got=%0d/%0d exp=0/1", state, stall_cnt); end
    idle_inputs();
    // rs2-only dependency
    EX_mem_read = 1'b1; EX_reg_wen = 1'b1; EX_reg_addr = 5'd7;
    ID_rs2_addr = 5'd7; ID_use_rs2 = 1'b1; ID_rs1_addr = 5'd3; ID_use_rs1 = 1'b1;
    #1;
    checks++; if (ctrl !== LU) begin failures++; $display("FAIL lu_rs2 got=%b exp=%b", ctrl, LU); end
    ID_use_rs2 = 1'b0;
    #1;
    checks++; if (ctrl !== IDLE) begin failures++; $display("FAIL lu_rs2_unused got=%b exp=%b", ctrl, IDLE); end
    ID_use_rs2 = 1'b1; EX_reg_wen = 1'b0;
    #1;
    checks++; if (ctrl !== IDLE) begin failures++; $display("FAIL lu_no_wen got=%b exp=%b", ctrl, IDLE); end
    idle_inputs();
    tick();
  endtask

  task automatic test_x0();
    do_reset();
    set_lu(5'd0);
    #1;
    checks++; if (ctrl !== IDLE) begin failures++; $display("FAIL x0_ctrl got=%b exp=%b", ctrl, IDLE); end
    tick();
    checks++; if (stall_cnt !== 4'd0 || state !== 2'd0) begin
      failures++; $display("FAIL x0_regs got=%0d/%0d exp=0/0", stall_cnt, state); end
    idle_inputs();
  endtask

  task automatic test_redirect();
    do_reset();
    set_lu(5'd9);
    EX_redirect = 1'b1;
    #1;
    checks++; if (ctrl !== REDR) begin failures++; $display("FAIL redir_ctrl got=%b exp=%b", ctrl, REDR); end
    tick();
    checks++; if (state !== 2'd3 || stall_cnt !== 4'd0) begin
      failures++; $display("FAIL redir_state got=%0d/%0d exp=3/0", state, stall_cnt); end
    idle_inputs();
    tick();
    checks++; if (state !== 2'd0) begin failures++; $display("FAIL redir_back got=%0d exp=0", state); end
  endtask

  task automatic test_mem_wait();
    do_reset();
    mem_busy = 1'b1;
    EX_redirect = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      #1;
      checks++; if (ctrl !== MEMW) begin failures++; $display("FAIL memw_ctrl%0d got=%b exp=%b", i, ctrl, MEMW); end
      tick();
      checks++; if (state !== 2'd2 || busy_cnt !== 8'(i)) begin
        failures++; $display("FAIL memw_state%0d got=%0d/%0d exp=2/%0d", i, state, busy_cnt, i); end
    end
    mem_busy = 1'b0;
    #1;
    checks++; if (ctrl !== REDR) begin failures++; $display("FAIL memw_flush got=%b exp=%b", ctrl, REDR); end
    tick();
    checks++; if (state !== 2'd3 || stall_cnt !== 4'd3 || busy_cnt !== 8'd0) begin
      failures++; $display("FAIL memw_end got=%0d/%0d/%0d exp=3/3/0", state, stall_cnt, busy_cnt); end
    idle_inputs();
  endtask

  task automatic test_timeout();
    do_reset();
    mem_busy = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      checks++; if (mem_timeout_err !== (i >= 4)) begin
        failures++; $display("FAIL timeout_edge%0d got=%b exp=%b", i, mem_timeout_err, (i >= 4)); end
    end
    mem_busy = 1'b0;
    tick();
    checks++; if (mem_timeout_err !== 1'b1 || busy_cnt !== 8'd0) begin
      failures++; $display("FAIL timeout_sticky got=%b/%0d exp=1/0", mem_timeout_err, busy_cnt); end
    tick();
    checks++; if (mem_timeout_err !== 1'b1) begin failures++; $display("FAIL timeout_hold got=%b exp=1", mem_timeout_err); end
    do_reset();
    checks++; if (mem_timeout_err !== 1'b0) begin failures++; $display("FAIL timeout_clear got=%b exp=0", mem_timeout_err); end
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    mem_busy = 1'b1;
    tick();
    tick();
    checks++; if (state !== 2'd2 || stall_cnt !== 4'd2) begin
      failures++; $display("FAIL midrst_pre got=%0d/%0d exp=2/2", state, stall_cnt); end
    rst = 1'b1;
    #1;
    checks++; if (ctrl !== IDLE) begin failures++; $display("FAIL midrst_ctrl got=%b exp=%b", ctrl, IDLE); end
    tick();
    checks++; if (state !== 2'd0 || stall_cnt !== 4'd0 || busy_cnt !== 8'd0) begin
      failures++; $display("FAIL midrst_regs got=%0d/%0d/%0d exp=0/0/0", state, stall_cnt, busy_cnt); end
    rst = 1'b0;
    mem_busy = 1'b0;
    #1;
    checks++; if (ctrl !== IDLE) begin failures++; $display("FAIL midrst_after got=%b exp=%b", ctrl, IDLE); end
  endtask

  task automatic test_saturation();
    do_reset();
    mem_busy = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    checks++; if (stall_cnt !== 4'hF) begin failures++; $display("FAIL sat_stall got=%0d exp=15", stall_cnt); end
    for (int i = 0; i < 240; i++) tick();
    checks++; if (busy_cnt !== 8'd255 || stall_cnt !== 4'hF) begin
      failures++; $display("FAIL sat_busy got=%0d/%0d exp=255/15", busy_cnt, stall_cnt); end
    idle_inputs();
    tick();
  endtask

  task automatic test_back_to_back();
    do_reset();
    EX_redirect = 1'b1;
    tick();
    EX_redirect = 1'b0;
    set_lu(5'd12);
    #1;
    checks++; if (ctrl !== LU) begin failures++; $display("FAIL b2b_lu got=%b exp=%b", ctrl, LU); end
    tick();
    checks++; if (state !== 2'd1 || stall_cnt !== 4'd1) begin
      failures++; $display("FAIL b2b_state got=%0d/%0d exp=1/1", state, stall_cnt); end
    mem_busy = 1'b1;
    #1;
    checks++; if (ctrl !== MEMW) begin failures++; $display("FAIL b2b_mem got=%b exp=%b", ctrl, MEMW); end
    tick();
    mem_busy = 1'b0;
    #1;
    checks++; if (ctrl !== LU) begin failures++; $display("FAIL b2b_deferred got=%b exp=%b", ctrl, LU); end
    idle_inputs();
    tick();
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    test_reset();
    test_load_use();
    test_x0();
    test_redirect();
    test_mem_wait();
    test_timeout();
    test_reset_mid_wait();
    test_saturation();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
